// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV64M multiply/divide unit for the execute stage.
//
// Sits beside the single-cycle ALU and takes the same forwarded operand pair.
// Multiplies use shift-add and divides use restoring division, one bit per
// cycle. The unit runs 64 iterations for 64-bit ops and 32 for W ops.
// Divide-by-zero, signed overflow and illegal op codes are resolved when the
// request is accepted. With SHORTCUT=1 they finish in a single cycle.
//
// Ports:
//   clk      rising-edge clock
//   resetn   asynchronous active-low reset
//   valid_i  request valid from ID/EX     ready_o  unit idle, can accept
//   op_i     operation code               a_i/b_i  operands (rs1/rs2)
//   flush_i  abort any in-flight op       valid_o  result valid to EX/MEM
//   ready_i  downstream accepts result    c_o      result
//   busy_o   unit in CALC or DONE (pipeline stall)
module muldiv_unit #(
    parameter int SHORTCUT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [3:0]  op_i,
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        flush_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [63:0] c_o,
    output logic        busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    logic [1:0]  state_q, state_d;
    logic [6:0]  cnt_q,   cnt_d;
    logic        w_q,     w_d;       // 32-bit (W) operation
    logic        mul_q,   mul_d;
    logic        rem_q,   rem_d;
    logic        neg_q,   neg_d;     // final result must be negated
    logic        spec_q,  spec_d;    // result already decided at accept
    logic [63:0] x_q,     x_d;       // mul: accumulator / div: partial remainder
    logic [63:0] y_q,     y_d;       // mul: multiplicand / div: dividend-quotient shifter
    logic [63:0] z_q,     z_d;       // mul: multiplier / div: divisor magnitude
    logic [63:0] c_q,     c_d;

    // ---------------- request decode ----------------
    logic        in_w, in_mul, in_signed, in_rem, in_illegal;
    logic [63:0] a_ext, b_ext, mag_a, mag_b, a_min;
    logic        sign_a, sign_b, b_zero, ovf, in_special;
    logic [63:0] spec_val;

    always_comb begin
        in_w       = op_i[3];
        in_mul     = (op_i[2:0] == 3'd0);
        in_signed  = (op_i[2:0] == 3'd1) || (op_i[2:0] == 3'd3);
        in_rem     = (op_i[2:0] == 3'd3) || (op_i[2:0] == 3'd4);
        in_illegal = (op_i[2:0] > 3'd4);

        // MULW is sign-extended too: only the low 32 product bits are kept.
        if (in_w && (in_signed || in_mul)) begin
            a_ext = sext32(a_i[31:0]);
            b_ext = sext32(b_i[31:0]);
        end else if (in_w) begin
            a_ext = {32'd0, a_i[31:0]};
            b_ext = {32'd0, b_i[31:0]};
        end else begin
            a_ext = a_i;
            b_ext = b_i;
        end

        sign_a = in_signed && a_ext[63];
        sign_b = in_signed && b_ext[63];
        mag_a  = sign_a ? -a_ext : a_ext;
        mag_b  = sign_b ? -b_ext : b_ext;

        a_min  = in_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        b_zero = (b_ext == 64'd0);
        ovf    = in_signed && (a_ext == a_min) && (b_ext == '1);

        in_special = in_illegal || (!in_mul && b_zero) || ovf;

        spec_val = 64'd0;
        if (in_illegal)
            spec_val = 64'd0;
        else if (b_zero && in_rem)
            spec_val = in_w ? sext32(a_i[31:0]) : a_i;
        else if (b_zero)
            spec_val = '1;
        else if (ovf && !in_rem)
            spec_val = a_ext;
    end

    // ---------------- one iteration step ----------------
    logic [63:0] mul_sum;
    logic [64:0] div_t, div_r;
    logic        div_ge;
    logic [63:0] quo_next, mag_res, signed_res, fin_res;

    always_comb begin
        mul_sum  = x_q + (z_q[0] ? y_q : 64'd0);
        div_t    = {x_q, y_q[63]};
        div_ge   = (div_t >= {1'b0, z_q});
        div_r    = div_ge ? (div_t - {1'b0, z_q}) : div_t;
        quo_next = {y_q[62:0], div_ge};

        if (mul_q)
            mag_res = mul_sum;
        else if (rem_q)
            mag_res = div_r[63:0];
        else
            mag_res = quo_next;

        signed_res = neg_q ? -mag_res : mag_res;
        fin_res    = w_q ? sext32(signed_res[31:0]) : signed_res;
    end

    // ---------------- next-state logic ----------------
    // NOTE: every signal assigned here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        mul_d   = mul_q;
        rem_d   = rem_q;
        neg_d   = neg_q;
        spec_d  = spec_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        c_d     = c_q;

        case (state_q)
            S_IDLE: begin
                if (valid_i && !flush_i) begin
                    w_d    = in_w;
                    mul_d  = in_mul;
                    rem_d  = in_rem;
                    neg_d  = in_rem ? sign_a : (sign_a ^ sign_b);
                    spec_d = in_special;
                    x_d    = 64'd0;
                    if (in_mul) begin
                        y_d = a_ext;
                        z_d = b_ext;
                    end else begin
                        // W dividends sit in the top half so the first 32
                        // shifts pull exactly their bits into the remainder.
                        y_d = in_w ? {mag_a[31:0], 32'd0} : mag_a;
                        z_d = mag_b;
                    end
                    if (in_special)
                        c_d = spec_val;
                    if (in_special && (SHORTCUT != 0)) begin
                        state_d = S_DONE;
                        cnt_d   = 7'd0;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = in_w ? 7'd32 : 7'd64;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - 7'd1;
                if (mul_q) begin
                    x_d = mul_sum;
                    y_d = {y_q[62:0], 1'b0};
                    z_d = {1'b0, z_q[63:1]};
                end else begin
                    x_d = div_r[63:0];
                    y_d = quo_next;
                end
                if (cnt_q == 7'd1) begin
                    state_d = S_DONE;
                    if (!spec_q)
                        c_d = fin_res;
                end
            end
            S_DONE: begin
                if (ready_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = 7'd0;
        end
    end

    // NOTE: datapath registers are reset along with control so that c_o and
    // every internal value come up in a defined state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 7'd0;
            w_q     <= 1'b0;
            mul_q   <= 1'b0;
            rem_q   <= 1'b0;
            neg_q   <= 1'b0;
            spec_q  <= 1'b0;
            x_q     <= 64'd0;
            y_q     <= 64'd0;
            z_q     <= 64'd0;
            c_q     <= 64'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            mul_q   <= mul_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
            spec_q  <= spec_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    assign ready_o = (state_q == S_IDLE);
    assign valid_o = (state_q == S_DONE);
    assign busy_o  = (state_q != S_IDLE);
    assign c_o     = c_q;

endmodule
